// File: rtl/bus_pkg.sv
// Shared definitions for the burst master port: state encoding
// and width helpers used by the interface and the datapath.
package bus_pkg;

   typedef enum logic [3:0] {
      S_IDLE,
      S_LOAD,
      S_REQ,
      S_SADDR,
      S_WAIT,
      S_ADDR,
      S_BLEN,
      S_WDATA,
      S_RDATA,
      S_SPLIT
   } state_t;

   function automatic int dev_w(int aw, int sw);
      return aw - sw;
   endfunction

   function automatic int len_w(int max_burst);
      return $clog2(max_burst);
   endfunction

   // Phase counter must hold the longest fixed-length serial phase
   function automatic int cnt_w(int a, int b, int c, int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/burst_master_port_if.sv
// Device-side request/beat handshakes plus the serial bus wires
// of the burst master port.
interface burst_master_port_if
   import bus_pkg::*;
#(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 8,
   parameter int MAX_BURST  = 4
);
   localparam int LEN_W = len_w(MAX_BURST);

   logic [ADDR_WIDTH-1:0] daddr;
   logic [LEN_W-1:0]      dlen;
   logic                  dmode;
   logic                  dvalid;
   logic                  dready;
   logic [DATA_WIDTH-1:0] dwdata;
   logic                  dwvalid;
   logic                  dwready;
   logic [DATA_WIDTH-1:0] drdata;
   logic                  drvalid;
   logic                  derr;
   logic                  mwdata;
   logic                  mmode;
   logic                  mvalid;
   logic                  mrdata;
   logic                  svalid;
   logic                  mbreq;
   logic                  mbgrant;
   logic                  msplit;
   logic                  ack;

   modport master (
      input  daddr, dlen, dmode, dvalid, dwdata, dwvalid,
      input  mrdata, svalid, mbgrant, msplit, ack,
      output dready, dwready, drdata, drvalid, derr,
      output mwdata, mmode, mvalid, mbreq
   );

   modport slave (
      output daddr, dlen, dmode, dvalid, dwdata, dwvalid,
      output mrdata, svalid, mbgrant, msplit, ack,
      input  dready, dwready, drdata, drvalid, derr,
      input  mwdata, mmode, mvalid, mbreq
   );

endinterface

// File: rtl/burst_wbuf.sv
// Write staging FIFO: holds the beats of one write burst until
// the serial data phase drains them in push order.
module burst_wbuf #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   clr,
   input  logic                   push,
   input  logic                   pop,
   input  logic [WIDTH-1:0]       wdata,
   output logic [WIDTH-1:0]       rdata,
   output logic [$clog2(DEPTH):0] count
);
   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL = (PW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wptr;
   logic [PW-1:0]    rptr;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && (count != FULL);
   assign do_pop  = pop && (count != '0);
   assign rdata   = mem[rptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wptr] <= wdata;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else if (clr) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (do_push) wptr <= wptr + PW'(1);
         if (do_pop)  rptr <= rptr + PW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (PW + 1)'(1);
            2'b01:   count <= count - (PW + 1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/burst_master_port.sv
// Burst master port: arbitrates for the serial bus, shifts out
// device/address/length/data and collects serial read beats.
module burst_master_port
   import bus_pkg::*;
#(
   parameter int ADDR_WIDTH           = 16,
   parameter int DATA_WIDTH           = 8,
   parameter int SLAVE_MEM_ADDR_WIDTH = 12,
   parameter int MAX_BURST            = 4,
   parameter int TIMEOUT_CYCLES       = 5,
   parameter int MAX_RETRY            = 2
) (
   input  logic                clk,
   input  logic                rstn,
   burst_master_port_if.master bus
);
   localparam int DEV_W = dev_w(ADDR_WIDTH, SLAVE_MEM_ADDR_WIDTH);
   localparam int LEN_W = len_w(MAX_BURST);
   localparam int CNT_W =
      cnt_w(SLAVE_MEM_ADDR_WIDTH, DEV_W, TIMEOUT_CYCLES, LEN_W);
   localparam int BIT_W = $clog2(DATA_WIDTH);
   localparam int RTY_W = $clog2(MAX_RETRY + 1);
   localparam int TX_W  =
      (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;

   localparam logic [CNT_W-1:0] DEV_LAST = CNT_W'(DEV_W - 1);
   localparam logic [CNT_W-1:0] SM_LAST  =
      CNT_W'(SLAVE_MEM_ADDR_WIDTH - 1);
   localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] LEN_LAST = CNT_W'(LEN_W - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);
   localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);
   localparam logic [LEN_W:0]   WB_FULL  = (LEN_W + 1)'(MAX_BURST);

   state_t                state;
   state_t                state_n;
   logic [ADDR_WIDTH-1:0] addr;
   logic [LEN_W-1:0]      len;
   logic                  mode;
   logic [RTY_W-1:0]      retry;
   logic [CNT_W-1:0]      cnt;
   logic [BIT_W-1:0]      bit_cnt;
   logic [LEN_W-1:0]      beat;
   logic [TX_W-1:0]       tx;
   logic [DATA_WIDTH-1:0] rx;
   logic [DATA_WIDTH-1:0] rx_n;
   logic [DATA_WIDTH-1:0] drdata_q;
   logic                  drvalid_q;
   logic                  derr_q;

   logic                  dready_c;
   logic                  dwready_c;
   logic                  mvalid_c;
   logic                  mbreq_c;
   logic                  accept;
   logic                  push;
   logic                  pop;
   logic                  bit_last;
   logic                  beat_last;
   logic [DATA_WIDTH-1:0] wb_rdata;
   logic [LEN_W:0]        wb_count;

   assign bit_last  = (bit_cnt == BIT_LAST);
   assign beat_last = (beat == len);
   assign rx_n      = {bus.mrdata, rx[DATA_WIDTH-1:1]};
   assign accept    = (state == S_IDLE) && bus.dvalid;
   assign push      = (state == S_LOAD) && bus.dwvalid && dwready_c;
   assign pop       =
      ((state == S_BLEN) && (cnt == LEN_LAST) && mode) ||
      ((state == S_WDATA) && bit_last && !beat_last);

   burst_wbuf #(
      .DEPTH (MAX_BURST),
      .WIDTH (DATA_WIDTH)
   ) u_wbuf (
      .clk   (clk),
      .rstn  (rstn),
      .clr   (accept),
      .push  (push),
      .pop   (pop),
      .wdata (bus.dwdata),
      .rdata (wb_rdata),
      .count (wb_count)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= S_IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n   = state;
      dready_c  = 1'b0;
      dwready_c = 1'b0;
      mvalid_c  = 1'b0;
      mbreq_c   = !(state inside {S_IDLE, S_LOAD});
      unique case (state)
         S_IDLE: begin
            dready_c = 1'b1;
            if (bus.dvalid) state_n = bus.dmode ? S_LOAD : S_REQ;
         end
         S_LOAD: begin
            dwready_c = (wb_count != WB_FULL);
            if (bus.dwvalid && dwready_c && beat_last) state_n = S_REQ;
         end
         S_REQ: if (bus.mbgrant) state_n = S_SADDR;
         S_SADDR: begin
            mvalid_c = 1'b1;
            if (cnt == DEV_LAST) state_n = S_WAIT;
         end
         S_WAIT: begin
            if (bus.ack)
               state_n = S_ADDR;
            else if (cnt == TO_LAST)
               state_n = (retry < RTY_MAX) ? S_REQ : S_IDLE;
         end
         S_ADDR: begin
            mvalid_c = 1'b1;
            if (cnt == SM_LAST) state_n = S_BLEN;
         end
         S_BLEN: begin
            mvalid_c = 1'b1;
            if (cnt == LEN_LAST) state_n = mode ? S_WDATA : S_RDATA;
         end
         S_WDATA: begin
            mvalid_c = 1'b1;
            if (bit_last && beat_last) state_n = S_IDLE;
         end
         S_RDATA: begin
            if (bus.msplit)
               state_n = S_SPLIT;
            else if (bus.svalid && bit_last && beat_last)
               state_n = S_IDLE;
         end
         S_SPLIT: if (!bus.msplit) state_n = S_RDATA;
         default: state_n = S_IDLE;
      endcase
   end

   // tx is reloaded at each phase boundary and shifted LSB first
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         addr      <= '0;
         len       <= '0;
         mode      <= 1'b0;
         retry     <= '0;
         cnt       <= '0;
         bit_cnt   <= '0;
         beat      <= '0;
         tx        <= '0;
         rx        <= '0;
         drdata_q  <= '0;
         drvalid_q <= 1'b0;
         derr_q    <= 1'b0;
      end else begin
         drvalid_q <= 1'b0;
         derr_q    <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (bus.dvalid) begin
                  addr    <= bus.daddr;
                  len     <= bus.dlen;
                  mode    <= bus.dmode;
                  retry   <= '0;
                  cnt     <= '0;
                  bit_cnt <= '0;
                  beat    <= '0;
               end
            end
            S_LOAD: begin
               if (push) beat <= beat_last ? '0 : beat + LEN_W'(1);
            end
            S_REQ: begin
               if (bus.mbgrant) begin
                  cnt <= '0;
                  tx  <= TX_W'(addr >> SLAVE_MEM_ADDR_WIDTH);
               end
            end
            S_SADDR: begin
               tx  <= tx >> 1;
               cnt <= (cnt == DEV_LAST) ? '0 : cnt + CNT_W'(1);
            end
            S_WAIT: begin
               if (bus.ack) begin
                  cnt <= '0;
                  tx  <= TX_W'(addr);
               end else if (cnt == TO_LAST) begin
                  cnt <= '0;
                  if (retry < RTY_MAX) retry  <= retry + RTY_W'(1);
                  else                 derr_q <= 1'b1;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            S_ADDR: begin
               if (cnt == SM_LAST) begin
                  cnt <= '0;
                  tx  <= TX_W'(len);
               end else begin
                  cnt <= cnt + CNT_W'(1);
                  tx  <= tx >> 1;
               end
            end
            S_BLEN: begin
               if (cnt == LEN_LAST) begin
                  cnt     <= '0;
                  bit_cnt <= '0;
                  beat    <= '0;
                  tx      <= mode ? TX_W'(wb_rdata) : '0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
                  tx  <= tx >> 1;
               end
            end
            S_WDATA: begin
               if (bit_last) begin
                  bit_cnt <= '0;
                  if (beat_last) begin
                     beat <= '0;
                     tx   <= '0;
                  end else begin
                     beat <= beat + LEN_W'(1);
                     tx   <= TX_W'(wb_rdata);
                  end
               end else begin
                  bit_cnt <= bit_cnt + BIT_W'(1);
                  tx      <= tx >> 1;
               end
            end
            S_RDATA: begin
               if (!bus.msplit && bus.svalid) begin
                  rx <= rx_n;
                  if (bit_last) begin
                     bit_cnt   <= '0;
                     drdata_q  <= rx_n;
                     drvalid_q <= 1'b1;
                     beat      <= beat_last ? '0 : beat + LEN_W'(1);
                  end else begin
                     bit_cnt <= bit_cnt + BIT_W'(1);
                  end
               end
            end
            S_SPLIT: ;
            default: ;
         endcase
      end
   end

   assign bus.dready  = dready_c;
   assign bus.dwready = dwready_c;
   assign bus.mvalid  = mvalid_c;
   assign bus.mwdata  = mvalid_c & tx[0];
   assign bus.mbreq   = mbreq_c;
   assign bus.mmode   = mode;
   assign bus.drdata  = drdata_q;
   assign bus.drvalid = drvalid_q;
   assign bus.derr    = derr_q;

endmodule

// File: tb/tb_burst_master_port.sv
// Directed bench for burst_master_port: write, read, split,
// retry/timeout and mid-burst reset scenarios.
module tb_burst_master_port;

   logic clk;
   logic rstn;
   int   errors;
   int   checks;

   bit        ser[$];
   logic [7:0] rd[$];
   int        n_drv;
   int        n_derr;
   int        n_sstart;
   logic      prev_mv;

   burst_master_port_if #(
      .ADDR_WIDTH (16),
      .DATA_WIDTH (8),
      .MAX_BURST  (4)
   ) bus ();

   burst_master_port #(
      .ADDR_WIDTH           (16),
      .DATA_WIDTH           (8),
      .SLAVE_MEM_ADDR_WIDTH (12),
      .MAX_BURST            (4),
      .TIMEOUT_CYCLES       (5),
      .MAX_RETRY            (2)
   ) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (bus.mvalid) ser.push_back(bus.mwdata);
      if (bus.mvalid && !prev_mv) n_sstart++;
      prev_mv = bus.mvalid;
      if (bus.drvalid) begin
         n_drv++;
         rd.push_back(bus.drdata);
      end
      if (bus.derr) n_derr++;
   end

   task automatic step();
      @(negedge clk);
      #2;
   endtask

   task automatic wait_idle(input int limit, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < limit; k++) begin
         step();
         if (bus.dready) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_rdata(input int hdr, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 100; k++) begin
         step();
         if (ser.size() == hdr && !bus.mvalid) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   function automatic logic [63:0] ser_word();
      logic [63:0] w;
      w = '0;
      foreach (ser[i]) if (i < 64) w[i] = ser[i];
      return w;
   endfunction

   task automatic drv_write(input logic [15:0] a, input logic [1:0] l,
                            input logic [31:0] beats);
      bus.daddr  = a;
      bus.dlen   = l;
      bus.dmode  = 1'b1;
      bus.dvalid = 1'b1;
      step();
      bus.dvalid = 1'b0;
      for (int i = 0; i <= int'(l); i++) begin
         bus.dwvalid = 1'b1;
         bus.dwdata  = beats[8*i +: 8];
         step();
      end
      bus.dwvalid = 1'b0;
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      step();
      checks++;
      if (bus.mvalid !== 1'b0 || bus.mbreq !== 1'b0) begin
         errors++;
         $display("FAIL reset_hold: mvalid=%b mbreq=%b want 0 0",
                  bus.mvalid, bus.mbreq);
      end
      step();
      rstn = 1'b1;
      step();
      checks++;
      if (bus.dready !== 1'b1) begin
         errors++;
         $display("FAIL reset_dready: got %b want 1", bus.dready);
      end
      checks++;
      if (bus.dwready !== 1'b0 || bus.mwdata !== 1'b0) begin
         errors++;
         $display("FAIL reset_dw_mw: dwready=%b mwdata=%b want 0 0",
                  bus.dwready, bus.mwdata);
      end
      checks++;
      if (bus.drvalid !== 1'b0 || bus.derr !== 1'b0) begin
         errors++;
         $display("FAIL reset_pulses: drvalid=%b derr=%b want 0 0",
                  bus.drvalid, bus.derr);
      end
      checks++;
      if (bus.drdata !== 8'h00 || bus.mmode !== 1'b0) begin
         errors++;
         $display("FAIL reset_regs: drdata=%h mmode=%b want 00 0",
                  bus.drdata, bus.mmode);
      end
   endtask

   task automatic test_write();
      logic [63:0] exp;
      logic [31:0] beats;
      bit          ok;
      int          d0;
      exp   = {8'hD4, 8'hC3, 8'hB2, 8'hA1, 2'b11, 12'h234, 4'h1};
      beats = 32'hD4C3B2A1;
      ser.delete();
      d0 = n_derr;
      bus.daddr  = 16'h1234;
      bus.dlen   = 2'd3;
      bus.dmode  = 1'b1;
      bus.dvalid = 1'b1;
      step();
      bus.dvalid = 1'b0;
      checks++;
      if (bus.dwready !== 1'b1 || bus.dready !== 1'b0) begin
         errors++;
         $display("FAIL wr_load: dwready=%b dready=%b want 1 0",
                  bus.dwready, bus.dready);
      end
      checks++;
      if (bus.mmode !== 1'b1 || bus.mbreq !== 1'b0) begin
         errors++;
         $display("FAIL wr_load_mode: mmode=%b mbreq=%b want 1 0",
                  bus.mmode, bus.mbreq);
      end
      for (int i = 0; i < 4; i++) begin
         bus.dwvalid = 1'b1;
         bus.dwdata  = beats[8*i +: 8];
         step();
      end
      bus.dwvalid = 1'b0;
      checks++;
      if (bus.mbreq !== 1'b1) begin
         errors++;
         $display("FAIL wr_req: mbreq=%b want 1", bus.mbreq);
      end
      wait_idle(200, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL wr_idle: timeout waiting for dready");
      end
      checks++;
      if (ser.size() != 50) begin
         errors++;
         $display("FAIL wr_bits: got %0d bits want 50", ser.size());
      end
      checks++;
      if (ser_word() !== exp) begin
         errors++;
         $display("FAIL wr_serial: got %h want %h", ser_word(), exp);
      end
      checks++;
      if (n_derr != d0) begin
         errors++;
         $display("FAIL wr_derr: got %0d pulses want 0", n_derr - d0);
      end
   endtask

   task automatic test_read();
      logic [15:0] stream;
      logic [63:0] exp;
      bit          ok;
      stream = 16'hC35A;
      exp    = {2'b01, 12'h010, 4'h2};
      ser.delete();
      rd.delete();
      bus.daddr  = 16'h2010;
      bus.dlen   = 2'd1;
      bus.dmode  = 1'b0;
      bus.dvalid = 1'b1;
      step();
      bus.dvalid = 1'b0;
      wait_rdata(18, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL rd_hdr_wait: timeout, bits=%0d", ser.size());
      end
      checks++;
      if (ser_word() !== exp) begin
         errors++;
         $display("FAIL rd_hdr: got %h want %h", ser_word(), exp);
      end
      for (int i = 0; i < 16; i++) begin
         bus.svalid = 1'b1;
         bus.mrdata = stream[i];
         step();
         if (i == 7) begin
            checks++;
            if (bus.drvalid !== 1'b1 || bus.drdata !== 8'h5A) begin
               errors++;
               $display("FAIL rd_beat0: drvalid=%b drdata=%h want 1 5a",
                        bus.drvalid, bus.drdata);
            end
         end
         if (i == 8) begin
            checks++;
            if (bus.drvalid !== 1'b0) begin
               errors++;
               $display("FAIL rd_pulse: drvalid=%b want 0", bus.drvalid);
            end
         end
      end
      bus.svalid = 1'b0;
      wait_idle(20, ok);
      checks++;
      if (!ok || rd.size() != 2) begin
         errors++;
         $display("FAIL rd_count: idle=%0b beats=%0d want 1 2",
                  ok, rd.size());
      end
      checks++;
      if (rd.size() == 2 && (rd[0] !== 8'h5A || rd[1] !== 8'hC3)) begin
         errors++;
         $display("FAIL rd_data: got %h %h want 5a c3", rd[0], rd[1]);
      end
   endtask

   task automatic test_split();
      logic [7:0]  val;
      logic [63:0] exp;
      bit          ok;
      int          n0;
      val = 8'h3C;
      exp = {2'b00, 12'hABC, 4'h0};
      ser.delete();
      rd.delete();
      bus.daddr  = 16'h0ABC;
      bus.dlen   = 2'd0;
      bus.dmode  = 1'b0;
      bus.dvalid = 1'b1;
      step();
      bus.dvalid = 1'b0;
      wait_rdata(18, ok);
      checks++;
      if (!ok || ser_word() !== exp) begin
         errors++;
         $display("FAIL sp_hdr: got %h want %h", ser_word(), exp);
      end
      for (int i = 0; i < 4; i++) begin
         bus.svalid = 1'b1;
         bus.mrdata = val[i];
         step();
      end
      n0 = n_drv;
      for (int k = 0; k < 10; k++) begin
         bus.msplit = 1'b1;
         bus.svalid = 1'b1;
         bus.mrdata = ~val[4 + (k % 4)];
         step();
      end
      checks++;
      if (bus.mbreq !== 1'b1) begin
         errors++;
         $display("FAIL sp_mbreq: got %b want 1", bus.mbreq);
      end
      bus.msplit = 1'b0;
      bus.svalid = 1'b0;
      step();
      checks++;
      if (n_drv != n0) begin
         errors++;
         $display("FAIL sp_extra: got %0d drvalid want 0", n_drv - n0);
      end
      for (int i = 4; i < 8; i++) begin
         bus.svalid = 1'b1;
         bus.mrdata = val[i];
         step();
      end
      bus.svalid = 1'b0;
      checks++;
      if (bus.drvalid !== 1'b1 || bus.drdata !== 8'h3C) begin
         errors++;
         $display("FAIL sp_data: drvalid=%b drdata=%h want 1 3c",
                  bus.drvalid, bus.drdata);
      end
      wait_idle(20, ok);
      checks++;
      if (!ok || rd.size() != 1) begin
         errors++;
         $display("FAIL sp_count: idle=%0b beats=%0d want 1 1",
                  ok, rd.size());
      end
   endtask

   task automatic test_retry();
      bit ok;
      int e0;
      int s0;
      int r0;
      ser.delete();
      e0 = n_derr;
      s0 = n_sstart;
      r0 = n_drv;
      bus.ack    = 1'b0;
      bus.daddr  = 16'h3ABC;
      bus.dlen   = 2'd0;
      bus.dmode  = 1'b0;
      bus.dvalid = 1'b1;
      step();
      bus.dvalid = 1'b0;
      wait_idle(200, ok);
      bus.ack = 1'b1;
      step();
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL rt_idle: timeout waiting for dready");
      end
      checks++;
      if (n_sstart - s0 != 3) begin
         errors++;
         $display("FAIL rt_attempts: got %0d want 3", n_sstart - s0);
      end
      checks++;
      if (n_derr - e0 != 1) begin
         errors++;
         $display("FAIL rt_derr: got %0d pulse cycles want 1",
                  n_derr - e0);
      end
      checks++;
      if (ser.size() != 12 || ser_word() !== 64'h333) begin
         errors++;
         $display("FAIL rt_serial: bits=%0d word=%h want 12 333",
                  ser.size(), ser_word());
      end
      checks++;
      if (n_drv != r0) begin
         errors++;
         $display("FAIL rt_drvalid: got %0d want 0", n_drv - r0);
      end
   endtask

   task automatic test_reset_mid();
      logic [63:0] exp;
      bit          ok;
      int          e0;
      ser.delete();
      e0 = n_derr;
      drv_write(16'h5678, 2'd3, 32'h44332211);
      ok = 1'b0;
      for (int k = 0; k < 100; k++) begin
         step();
         if (ser.size() >= 29) begin
            ok = 1'b1;
            break;
         end
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL rm_reach: bits=%0d want >=29", ser.size());
      end
      rstn = 1'b0;
      #1;
      checks++;
      if (bus.mvalid !== 1'b0 || bus.mwdata !== 1'b0 ||
          bus.mbreq !== 1'b0) begin
         errors++;
         $display("FAIL rm_bus: mvalid=%b mwdata=%b mbreq=%b want 0",
                  bus.mvalid, bus.mwdata, bus.mbreq);
      end
      checks++;
      if (bus.drdata !== 8'h00 || bus.mmode !== 1'b0 ||
          bus.dwready !== 1'b0) begin
         errors++;
         $display("FAIL rm_regs: drdata=%h mmode=%b dwready=%b want 0",
                  bus.drdata, bus.mmode, bus.dwready);
      end
      step();
      step();
      rstn = 1'b1;
      step();
      checks++;
      if (bus.dready !== 1'b1 || n_derr != e0 || ser.size() != 29) begin
         errors++;
         $display("FAIL rm_after: dready=%b derr=%0d bits=%0d want 1 0 29",
                  bus.dready, n_derr - e0, ser.size());
      end
      ser.delete();
      exp = {8'hA5, 8'h5A, 2'b01, 12'h234, 4'h1};
      drv_write(16'h1234, 2'd1, 32'h0000A55A);
      wait_idle(200, ok);
      checks++;
      if (!ok || ser.size() != 34) begin
         errors++;
         $display("FAIL rm_next_len: idle=%0b bits=%0d want 1 34",
                  ok, ser.size());
      end
      checks++;
      if (ser_word() !== exp) begin
         errors++;
         $display("FAIL rm_next_data: got %h want %h", ser_word(), exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      errors      = 0;
      checks      = 0;
      n_drv       = 0;
      n_derr      = 0;
      n_sstart    = 0;
      prev_mv     = 1'b0;
      rstn        = 1'b0;
      bus.daddr   = '0;
      bus.dlen    = '0;
      bus.dmode   = 1'b0;
      bus.dvalid  = 1'b0;
      bus.dwdata  = '0;
      bus.dwvalid = 1'b0;
      bus.mrdata  = 1'b0;
      bus.svalid  = 1'b0;
      bus.mbgrant = 1'b1;
      bus.msplit  = 1'b0;
      bus.ack     = 1'b1;
      test_reset();
      test_write();
      test_read();
      test_split();
      test_retry();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/burst_master_port.md
BURST_MASTER_PORT -- requirements
Module: burst_master_port

Interface
REQ-001 Parameters SHALL be: ADDR_WIDTH 16, address bits; DATA_WIDTH 8, beat width; SLAVE_MEM_ADDR_WIDTH 12, slave-local address bits; MAX_BURST 4, max beats per transaction (power of 2, >=2); TIMEOUT_CYCLES 5, ack wait limit; MAX_RETRY 2, re-arbitrations after timeout.
REQ-002 Derived: DEV_W = ADDR_WIDTH-SLAVE_MEM_ADDR_WIDTH; LEN_W = clog2(MAX_BURST).
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 Ports SHALL be:
- clk  in  1  clock
- rstn  in  1  async active-low reset
- daddr  in  ADDR_WIDTH  start address
- dlen  in  LEN_W  beats-1
- dmode  in  1  0 read, 1 write
- dvalid  in  1  request valid
- dready  out  1  request accepted when dvalid&&dready
- dwdata  in  DATA_WIDTH  write beat
- dwvalid  in  1  write beat valid
- dwready  out  1  write beat accepted
- drdata  out  DATA_WIDTH  read beat
- drvalid  out  1  one-cycle pulse per read beat
- derr  out  1  one-cycle pulse on abort
- mwdata  out  1  serial addr/len/data
- mmode  out  1  latched dmode
- mvalid  out  1  mwdata valid
- mrdata  in  1  serial read data
- svalid  in  1  mrdata valid
- mbreq  out  1  bus request
- mbgrant  in  1  bus grant
- msplit  in  1  slave split
- ack  in  1  address-decoder ack

Function
REQ-005 States SHALL be IDLE, LOAD, REQ, SADDR, WAIT, ADDR, BLEN, WDATA, RDATA, SPLIT.
REQ-006 IDLE: dready=1; on dvalid latch daddr/dlen/dmode, retry count=0; go LOAD if write else REQ.
REQ-007 LOAD: dwready=1; push beats into MAX_BURST-deep buffer; after dlen+1 beats go REQ next cycle.
REQ-008 REQ: mbreq=1; on mbgrant go SADDR; mbreq SHALL stay 1 in every state except IDLE and LOAD.
REQ-009 SADDR: DEV_W cycles, mvalid=1, mwdata=addr[SLAVE_MEM_ADDR_WIDTH+i], LSB first; then WAIT.
REQ-010 WAIT: mvalid=0; ack -> ADDR; after TIMEOUT_CYCLES without ack: retry<MAX_RETRY -> retry+1, REQ; else derr pulse, IDLE.
REQ-011 ADDR: SLAVE_MEM_ADDR_WIDTH cycles, mwdata=addr[i] LSB first; then BLEN.
REQ-012 BLEN: LEN_W cycles, mwdata=dlen LSB first; then WDATA if write else RDATA.
REQ-013 WDATA: (dlen+1)*DATA_WIDTH consecutive cycles, mvalid=1, beats in push order LSB first; then IDLE.
REQ-014 RDATA: mvalid=0; each svalid shifts mrdata into bit counter; on DATA_WIDTH-th bit drdata updates with drvalid pulse next cycle; after dlen+1 beats -> IDLE.
REQ-015 msplit in RDATA -> SPLIT; bit/beat counters SHALL hold; !msplit -> RDATA resume.
REQ-016 msplit and svalid same cycle in RDATA: msplit wins, bit not captured.
REQ-017 Counters SHALL be wide enough for largest phase; no wrap within a transaction.
REQ-018 dvalid outside IDLE and dwvalid outside LOAD SHALL be ignored.
REQ-019 mmode SHALL equal latched dmode from acceptance to next acceptance.

Reset
REQ-020 rstn low SHALL immediately force state IDLE, counters/buffer pointers 0, mvalid, mwdata, drvalid, derr, mbreq, dwready 0, drdata 0, mmode 0; dready 1 after release.
REQ-021 Reset mid-transaction SHALL abort without derr; no partial beat delivered.

Structure
REQ-022 State encoding, LEN_W/DEV_W helpers in shared package bus_pkg.
REQ-023 Write buffer SHALL be sub-module burst_wbuf (MAX_BURST x DATA_WIDTH FIFO, push/pop, count).

Verification
REQ-024 Write, daddr=0x1234, dlen=3, beats A1,B2,C3,D4, grant+ack immediate -> serial 0x1 (4b), 0x234 (12b), 3 (2b), 32 data bits LSB first, back to IDLE.
REQ-025 Read, daddr=0x2010, dlen=1, slave returns 0x5A,0xC3 -> drvalid twice, drdata 0x5A then 0xC3.
REQ-026 Read with msplit for 10 cycles after bit 3 -> drdata still correct, no extra drvalid.
REQ-027 No ack, MAX_RETRY=2 -> three REQ/SADDR attempts, then one derr pulse, IDLE.
REQ-028 rstn low during WDATA beat 2 -> all outputs zero same cycle, no derr, next request completes normally.
